// File: rtl/axi_line_refill.sv
// axi_line_refill: AXI4 INCR read-burst master filling one cache line; define
// YSYX_25040129_REFILL_PERF_EN to add saturating refill/busy-cycle counters.
module axi_line_refill #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [LINE_WORDS*32-1:0] resp_data,
  output logic                   resp_err,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [ADDR_W-1:0]      araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast
`ifdef YSYX_25040129_REFILL_PERF_EN
  ,
  output logic [31:0]            perf_refills,
  output logic [31:0]            perf_busy_cycles
`endif
);
  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  typedef enum logic [2:0] {IDLE, AR, R, DRAIN, RESP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [LINE_WORDS-1:0][31:0] line;
  logic beat, at_end;
  assign beat = rvalid && rready;
  assign at_end = cnt == LAST;
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid ? AR : IDLE;
      AR:      state_nxt = arready ? R : AR;
      R:       state_nxt = !beat ? R : rlast ? RESP : at_end ? DRAIN : R;
      DRAIN:   state_nxt = beat && rlast ? RESP : DRAIN;
      RESP:    state_nxt = resp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    arvalid = state == AR;
    rready = state == R || state == DRAIN;
    resp_valid = state == RESP;
  end
  assign arlen = 8'(LINE_WORDS - 1);
  assign arsize = 3'b010;
  assign arburst = 2'b01;
  assign resp_data = line;
  // A beat is in error if rresp flags it or rlast disagrees with the last-word position.
  always_ff @(posedge clock) begin
    if (reset) begin
      araddr <= '0;
      cnt <= '0;
      line <= '0;
      resp_err <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      araddr <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
      cnt <= '0;
      resp_err <= 1'b0;
    end else if (state == R && beat) begin
      line[cnt[CW-2:0]] <= rdata;
      cnt <= cnt + 1'b1;
      if (rresp != 2'b00 || rlast != at_end) resp_err <= 1'b1;
    end
  end
`ifdef YSYX_25040129_REFILL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_refills <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (state == RESP && resp_ready && perf_refills != '1) perf_refills <= perf_refills + 1'b1;
      if (state != IDLE && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_line_refill.sv
// tb_axi_line_refill: table-driven and randomized bench for axi_line_refill with a
// line-level reference model; perf counters checked when YSYX_25040129_REFILL_PERF_EN is set.
module tb_axi_line_refill;
  localparam int LW = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, resp_ready = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic req_ready, resp_valid, resp_err, arvalid, rready;
  logic [31:0] req_addr = '0, araddr, rdata = '0;
  logic [LW*32-1:0] resp_data;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp = 2'b00;
`ifdef YSYX_25040129_REFILL_PERF_EN
  logic [31:0] perf_refills, perf_busy_cycles;
`endif
  int n_chk = 0, n_pass = 0, refills = 0;
  typedef struct {logic [31:0] data; logic [1:0] resp;} beat_t;
  typedef struct {
    logic [31:0] addr;
    int ar_wait;
    int nbeats;
    int bad_at;
    logic [31:0] exp_araddr;
    int exp_err;
    int exp_lat;
  } vec_t;
  beat_t q[$];
  logic [31:0] exp_line [LW];
  logic exp_err;

  axi_line_refill #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
`ifdef YSYX_25040129_REFILL_PERF_EN
    , .perf_refills(perf_refills), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [LW*32-1:0] pack_line();
    logic [LW*32-1:0] r;
    for (int k = 0; k < LW; k++) r[k*32 +: 32] = exp_line[k];
    return r;
  endfunction

  // Line-level model: the first LW beats land in order, later beats vanish;
  // the refill is in error unless exactly LW beats arrive, or if a stored beat had rresp!=0.
  task automatic model();
    int n, st;
    n = q.size();
    st = n < LW ? n : LW;
    exp_err = n != LW;
    for (int k = 0; k < st; k++) begin
      exp_line[k] = q[k].data;
      if (q[k].resp != 2'b00) exp_err = 1'b1;
    end
  endtask

  task automatic fill(input int n, input int bad_at, input logic [31:0] base);
    beat_t b;
    q.delete();
    for (int k = 0; k < n; k++) begin
      b.data = base + 32'h11 * (k + 1);
      b.resp = (k == bad_at) ? 2'b10 : 2'b00;
      q.push_back(b);
    end
  endtask

  task automatic refill(input logic [31:0] addr, input int ar_wait, input int gap_pct,
                        input int exp_lat, input logic [31:0] exp_araddr, input int tab_err);
    int cyc, idx, budget, hold;
    model();
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_addr = addr;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    req_addr = $urandom;
    cyc = 1;
    chk("req_ready_busy", req_ready, 0);
    for (int w = 0; w <= ar_wait; w++) begin
      chk("arvalid_held", arvalid, 1);
      chk("araddr", araddr, exp_araddr);
      chk("rready_in_ar", rready, 0);
      arready = (w == ar_wait);
      @(negedge clock);
      cyc++;
    end
    arready = 1'b0;
    chk("arlen", arlen, LW - 1);
    chk("arsize_arburst", {arsize, arburst}, 5'b010_01);
    chk("arvalid_after_hs", arvalid, 0);
    idx = 0;
    budget = 400;
    while (idx < q.size() && budget > 0) begin
      rvalid = ($urandom_range(99) >= gap_pct);
      rdata = rvalid ? q[idx].data : $urandom;
      rresp = q[idx].resp;
      rlast = (idx == q.size() - 1);
      if (rvalid && rready) idx++;
      @(negedge clock);
      cyc++;
      budget--;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    chk("beats_accepted", idx, q.size());
    budget = 50;
    while (!resp_valid && budget > 0) begin
      @(negedge clock);
      cyc++;
      budget--;
    end
    chk("resp_valid", resp_valid, 1);
    if (exp_lat >= 0) chk("resp_latency", cyc, exp_lat);
    if (tab_err >= 0) chk("resp_err_table", resp_err, tab_err[0]);
    hold = $urandom_range(2);
    for (int h = 0; h <= hold; h++) begin
      chk("resp_data", resp_data, pack_line());
      chk("resp_err", resp_err, exp_err);
      chk("resp_valid_held", resp_valid, 1);
      chk("rready_in_resp", rready, 0);
      resp_ready = (h == hold);
      @(negedge clock);
    end
    resp_ready = 1'b0;
    refills++;
    chk("back_to_idle", {req_ready, resp_valid, arvalid}, 3'b100);
  endtask

  initial begin
    vec_t vt [6];
    logic [31:0] a;
    int n;
    beat_t b;
    vt[0] = '{32'h3000_0014, 0, 4, -1, 32'h3000_0010, 0, 6};
    vt[1] = '{32'h3000_002C, 5, 4, -1, 32'h3000_0020, 0, 11};
    vt[2] = '{32'h8000_0000, 0, 4, 1, 32'h8000_0000, 1, 6};
    vt[3] = '{32'h1234_567F, 0, 2, -1, 32'h1234_5670, 1, 4};
    vt[4] = '{32'h0000_0FFC, 0, 6, -1, 32'h0000_0FF0, 1, 8};
    vt[5] = '{32'h3000_0014, 0, 4, -1, 32'h3000_0010, 0, 6};
    for (int k = 0; k < LW; k++) exp_line[k] = '0;
    repeat (2) @(negedge clock);
    chk("rst_outputs", {req_ready, arvalid, rready, resp_valid, resp_err}, 5'b10000);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_araddr", araddr, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill(vt[i].nbeats, vt[i].bad_at, 32'(i) << 24);
      refill(vt[i].addr, vt[i].ar_wait, 0, vt[i].exp_lat, vt[i].exp_araddr, vt[i].exp_err);
    end

    for (int t = 0; t < 24; t++) begin
      n = ($urandom_range(3) == 0) ? $urandom_range(1, 7) : LW;
      a = $urandom;
      q.delete();
      for (int k = 0; k < n; k++) begin
        b.data = $urandom;
        b.resp = ($urandom_range(9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        q.push_back(b);
      end
      refill(a, $urandom_range(3), 30, -1, a & ~32'(LW * 4 - 1), -1);
    end

    @(negedge clock);
    req_addr = 32'h4000_0008;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk("rready_in_r", rready, 1);
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    rvalid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_outputs", {arvalid, rready, req_ready, resp_valid, resp_err}, 5'b00100);
    chk("midrst_resp_data", resp_data, '0);
    for (int k = 0; k < LW; k++) exp_line[k] = '0;
    refills = 0;

    for (int i = 0; i < 3; i++) begin
      fill(LW, -1, 32'hA000_0000 + 32'(i));
      refill(32'h2000_0040 * (i + 1), 0, 0, 6, 32'h2000_0040 * (i + 1), 0);
    end
`ifdef YSYX_25040129_REFILL_PERF_EN
    chk("perf_refills", perf_refills, refills);
    chk("perf_busy_nonzero", perf_busy_cycles != 0, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
